decimation: RTL and testbench
=============================

// Module: decimation
// PURPOSE
//  Averaging down-sampler, the ADC-side counterpart of the DAC-path interpolating up-sampler.
//  Accepts one signed sample per enabled clock and sums blocks of 2^SAMPLE_RATE samples.
//  Writes each block mean to a downstream FIFO with a one-cycle wr_en pulse.
//  Sits between the ADC capture register and the ADC FIFO write port.
// PARAMETERS
//  SAMPLE_RATE  4   log2 of decimation factor; N = 1<<SAMPLE_RATE samples per output
//  DATAWIDTH    14  sample width, two's complement, input and output
// PORTS
//  clk      in   1                   system clock, all logic on posedge
//  rst      in   1                   asynchronous, active-high reset
//  ena      in   1                   dataIn valid this cycle (ADC sample strobe)
//  dataIn   in   DATAWIDTH           signed input sample
//  full     in   1                   downstream FIFO full
//  clr_ovf  in   1                   synchronous clear of overflow flag
//  ds_data  out  DATAWIDTH           signed decimated sample (registered)
//  wr_en    out  1                   FIFO write strobe, one-cycle pulse
//  overflow out  1                   sticky: a block result was dropped because full=1
//  running  out  1                   1 while in state RUN
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, count=0, acc=0; ds_data=0, wr_en=0, overflow=0, running=0.
//  States: IDLE -> RUN on the first posedge with ena=1. No other transition except reset.
//   That first ena sample is accepted as sample 0 of block 0.
//  RUN: each posedge with ena=1 accepts dataIn. ena=0 holds count and acc unchanged.
//  count: SAMPLE_RATE bits, +1 per accepted sample, wraps N-1 -> 0.
//  acc: signed DATAWIDTH+SAMPLE_RATE bits, sums sign-extended samples. Cannot overflow.
//  Block end (accepted sample with count==N-1):
//   - sum = acc + sext(dataIn)
//   - ds_data <= sum >>> SAMPLE_RATE (arithmetic; floor toward -inf; no rounding)
//   - acc <= 0
//   - wr_en <= ~full, using full sampled at that same edge
//   - if full=1: result is dropped (ds_data still updates) and overflow <= 1
//  Latency: wr_en and the new ds_data are visible in the cycle after the edge
//   that accepted the block's last sample.
//  wr_en: high for exactly one cycle per block, then 0.
//   Max rate is one pulse per N cycles with continuous ena.
//  ds_data: holds its value between blocks.
//  overflow: sticky.
//   - clr_ovf=1 clears it at the next edge.
//   - If set and clear occur at the same edge, set wins (overflow=1).
//  rst mid-block: the partial sum is discarded. After release, wait in IDLE for ena;
//   the next block starts at count 0.
//  SAMPLE_RATE=0: every accepted sample is passed through with one-cycle latency.
// TESTING
//  1 rst pulse, ena=0 for 100 cycles, random dataIn -> wr_en never 1, ds_data=0, running=0.
//  2 SR=4, ena=1 continuous, dataIn=100 -> first wr_en the cycle after the 16th sample,
//    then every 16 cycles, ds_data=100.
//  3 ramp 0..15 -> ds_data=7 (120/16 floored);
//    alternating -1,0 x8 -> sum=-8, ds_data=-1 (14'h3FFF).
//  4 16x 8191 -> 8191; 16x -8192 -> -8192; no accumulator wrap.
//  5 full=1 at block end -> wr_en=0, overflow=1; next block with full=0 -> normal pulse,
//    overflow stays 1. Then clr_ovf=1 -> overflow=0. clr_ovf at the same edge as a new drop -> overflow=1.
//  6 ena 1/0 alternating -> block completes after 16 accepted samples (~32 cycles).
//    rst after 7 samples, then 16 samples of 50 -> ds_data=50.

Source files
------------

// File: rtl/decimation_if.sv
// Sample-stream and FIFO-write signal bundle for the averaging down-sampler.
// The slave modport is the decimator side; master is the ADC/FIFO side.
interface decimation_if #(
  parameter int unsigned DATAWIDTH = 14
);
  logic                 ena;
  logic [DATAWIDTH-1:0] dataIn;
  logic                 full;
  logic                 clr_ovf;
  logic [DATAWIDTH-1:0] ds_data;
  logic                 wr_en;
  logic                 overflow;
  logic                 running;

  modport master (
    output ena, dataIn, full, clr_ovf,
    input  ds_data, wr_en, overflow, running
  );

  modport slave (
    input  ena, dataIn, full, clr_ovf,
    output ds_data, wr_en, overflow, running
  );
endinterface

// File: rtl/decimation.sv
// Averaging down-sampler: sums blocks of 2^SAMPLE_RATE signed samples and
// writes each floored block mean to a downstream FIFO with a one-cycle strobe.
module decimation #(
  parameter int unsigned SAMPLE_RATE = 4,
  parameter int unsigned DATAWIDTH   = 14
) (
  input  logic          clk,
  input  logic          rst,
  decimation_if.slave   bus
);
  localparam int unsigned N  = 1 << SAMPLE_RATE;
  localparam int unsigned CW = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
  localparam int unsigned AW = DATAWIDTH + SAMPLE_RATE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [DATAWIDTH-1:0]  ds_q, ds_d;
  logic                  wr_q, wr_d;
  logic                  ovf_q, ovf_d;
  logic signed [AW-1:0]  din_ext;
  logic signed [AW-1:0]  sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      ds_q    <= '0;
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ds_q    <= ds_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ds_d    = ds_q;
    wr_d    = 1'b0;
    ovf_d   = bus.clr_ovf ? 1'b0 : ovf_q;
    din_ext = AW'($signed(bus.dataIn));
    sum     = acc_q + din_ext;

    case (state_q)
      IDLE:    if (bus.ena) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    // The strobe that leaves IDLE is also sample 0, so acceptance ignores state.
    if (bus.ena) begin
      if (count_q == CW'(N - 1)) begin
        count_d = '0;
        acc_d   = '0;
        ds_d    = DATAWIDTH'(sum >>> SAMPLE_RATE);
        wr_d    = ~bus.full;
        if (bus.full) ovf_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
        acc_d   = sum;
      end
    end
  end

  assign bus.ds_data  = ds_q;
  assign bus.wr_en    = wr_q;
  assign bus.overflow = ovf_q;
  assign bus.running  = (state_q == RUN);
endmodule

// File: tb/tb_decimation.sv
// Scoreboard bench for decimation: a block-mean model feeds an expected-write
// queue that a negedge monitor drains whenever wr_en is presented.
module tb_decimation;
  localparam int SR = 4;
  localparam int DW = 14;
  localparam int N  = 1 << SR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decimation_if #(.DATAWIDTH(DW)) bus ();
  decimation #(.SAMPLE_RATE(SR), .DATAWIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model state (post-edge values)
  int              m_samples[$];
  logic [DW-1:0]   m_ds;
  logic            m_wr, m_ovf, m_run;
  logic [DW-1:0]   exp_q[$];

  function automatic int floor_mean(input int s);
    int q;
    q = s / N;
    if ((s % N != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_samples.delete();
    exp_q.delete();
    m_ds = '0; m_wr = 1'b0; m_ovf = 1'b0; m_run = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge consume them, advance the model.
  task automatic cyc(input bit ena, input int din, input bit full, input bit clr);
    int s;
    logic [DW-1:0] r;
    bus.ena = ena; bus.dataIn = din[DW-1:0]; bus.full = full; bus.clr_ovf = clr;
    @(posedge clk);
    m_wr = 1'b0;
    if (clr) m_ovf = 1'b0;
    if (ena) begin
      m_run = 1'b1;
      m_samples.push_back(din);
      if (m_samples.size() == N) begin
        s = 0;
        foreach (m_samples[i]) s += m_samples[i];
        m_samples.delete();
        r = DW'(floor_mean(s));
        m_ds = r;
        if (full) m_ovf = 1'b1;
        else begin
          m_wr = 1'b1;
          exp_q.push_back(r);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  // Monitor: per-cycle flags against the model, data popped on each write.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    checks++;
    if (bus.wr_en !== m_wr) begin
      errors++;
      $display("FAIL wr_en: got %b expected %b at %0t", bus.wr_en, m_wr, $time);
    end
    if (bus.wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got ds_data %h with empty queue at %0t", bus.ds_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.ds_data !== e) begin
          errors++;
          $display("FAIL write_data: got %h expected %h at %0t", bus.ds_data, e, $time);
        end
      end
    end
    checks++;
    if (bus.ds_data !== m_ds || bus.overflow !== m_ovf || bus.running !== m_run) begin
      errors++;
      $display("FAIL state: got ds=%h ovf=%b run=%b expected ds=%h ovf=%b run=%b at %0t",
               bus.ds_data, bus.overflow, bus.running, m_ds, m_ovf, m_run, $time);
    end
  end

  initial begin
    bus.ena = 1'b0; bus.dataIn = '0; bus.full = 1'b0; bus.clr_ovf = 1'b0;
    model_reset();
    #1;
    do_reset();
    chk("reset_ds", int'(bus.ds_data), 0);
    chk("reset_running", int'(bus.running), 0);

    // 1: idle with random data
    for (int i = 0; i < 100; i++) cyc(1'b0, rnd_sample(), 1'b0, 1'b0);
    chk("idle_running", int'(bus.running), 0);
    chk("idle_ds", int'(bus.ds_data), 0);

    // 2: continuous constant 100
    for (int i = 0; i < 3 * N; i++) cyc(1'b1, 100, 1'b0, 1'b0);
    chk("const100", int'(bus.ds_data), 100);

    // 3: ramp and alternating -1/0
    for (int i = 0; i < N; i++) cyc(1'b1, i, 1'b0, 1'b0);
    chk("ramp", int'(bus.ds_data), 7);
    for (int i = 0; i < N; i++) cyc(1'b1, (i % 2 == 0) ? -1 : 0, 1'b0, 1'b0);
    chk("neg_floor", int'(bus.ds_data), 'h3FFF);

    // 4: extremes
    for (int i = 0; i < N; i++) cyc(1'b1, 8191, 1'b0, 1'b0);
    chk("max", int'(bus.ds_data), 8191);
    for (int i = 0; i < N; i++) cyc(1'b1, -8192, 1'b0, 1'b0);
    chk("min", int'(bus.ds_data), 'h2000);

    // 5: drop on full, sticky overflow, clear, clear colliding with drop
    for (int i = 0; i < N; i++) cyc(1'b1, 33, (i == N - 1), 1'b0);
    chk("drop_ovf", int'(bus.overflow), 1);
    chk("drop_wr", int'(bus.wr_en), 0);
    chk("drop_ds", int'(bus.ds_data), 33);
    for (int i = 0; i < N; i++) cyc(1'b1, -5, 1'b0, 1'b0);
    chk("sticky_ovf", int'(bus.overflow), 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("clr_ovf", int'(bus.overflow), 0);
    for (int i = 0; i < N; i++) cyc(1'b1, 12, (i == N - 1), (i == N - 1));
    chk("set_wins", int'(bus.overflow), 1);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // 6: gapped ena, then reset mid-block
    for (int i = 0; i < 2 * N; i++) cyc(i % 2 == 0, 200 + i, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 999, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_idle", int'(bus.running), 0);
    for (int i = 0; i < N; i++) cyc(1'b1, 50, 1'b0, 1'b0);
    chk("post_rst_block", int'(bus.ds_data), 50);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(3) != 0, rnd_sample(), $urandom_range(9) == 0, $urandom_range(19) == 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
